// File: rtl/adc_block_framer.sv
// Frames LTC2315 A/B sample pairs into fixed-length FIFO blocks, written only when the whole block fits.
// Optional channel-A amplitude-step trigger: define ADC_TRIGGER_EN.
module adc_block_framer #(
  parameter int BLOCK_LEN  = 256,
  parameter int FIFO_DEPTH = 512,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adc_cs,
  input  logic [15:0]      adc_data_a,
  input  logic [15:0]      adc_data_b,
  input  logic             start,
  input  logic [15:0]      porog,
  input  logic             porog_valid,
  input  logic [CNT_W-1:0] fifo_wr_count,
  output logic [15:0]      fifo_din_a,
  output logic [15:0]      fifo_din_b,
  output logic             fifo_wr_en,
  output logic             block_start,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       overflow_cnt,
  output logic             busy
);

  localparam int IDX_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] SPACE_LIM = CNT_W'(FIFO_DEPTH - BLOCK_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST_M1 = IDX_W'(BLOCK_LEN - 2);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_cs_f;
  logic             r_cs_ff;
  logic             w_strobe;
  logic [15:0]      r_smp_a;
  logic [15:0]      r_smp_b;
  logic             r_wr_en;
  logic             r_block_start;
  logic [15:0]      r_frame_cnt;
  logic [7:0]       r_overflow_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_space_ok;
  logic             w_start_cond;
  logic             w_write;
  logic             w_first_word;
  logic             w_ovf_inc;
  logic             w_frame_done;

  assign w_strobe   = r_cs_f & ~r_cs_ff;
  assign w_space_ok = (fifo_wr_count <= SPACE_LIM);

`ifdef ADC_TRIGGER_EN
  logic [15:0]        r_porog;
  logic [15:0]        r_prev_a;
  logic               r_first_arm;
  logic signed [16:0] w_diff;
  logic [16:0]        w_abs;

  assign w_diff       = $signed({adc_data_a[15], adc_data_a}) - $signed({r_prev_a[15], r_prev_a});
  assign w_abs        = w_diff[16] ? 17'(-w_diff) : 17'(w_diff);
  assign w_start_cond = ~r_first_arm & (w_abs > {1'b0, r_porog});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_porog     <= '1;
      r_prev_a    <= '0;
      r_first_arm <= 1'b1;
    end else begin
      if (porog_valid) r_porog <= porog;
      if (w_strobe)    r_prev_a <= adc_data_a;
      // Entry from IDLE wins over a coincident strobe so the next ARM strobe only seeds prev_a.
      if (r_state == S_IDLE && w_next_state == S_ARM) r_first_arm <= 1'b1;
      else if (w_strobe)                               r_first_arm <= 1'b0;
    end
  end
`else
  logic w_unused_trig;
  assign w_unused_trig = ^{porog, porog_valid};
  assign w_start_cond  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_first_word = 1'b0;
    w_ovf_inc    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_ARM;
      S_ARM: begin
        if (!start) begin
          w_next_state = S_IDLE;
        end else if (w_strobe && w_start_cond) begin
          if (w_space_ok) begin
            w_write      = 1'b1;
            w_first_word = 1'b1;
            w_next_state = S_CAPTURE;
          end else begin
            w_ovf_inc = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        // r_idx holds the index of the last word written; word 0 went out from ARM.
        if (w_strobe) begin
          w_write = 1'b1;
          if (r_idx == IDX_LAST_M1) begin
            w_frame_done = 1'b1;
            w_next_state = start ? S_ARM : S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_f         <= 1'b0;
      r_cs_ff        <= 1'b0;
      r_smp_a        <= '0;
      r_smp_b        <= '0;
      r_wr_en        <= 1'b0;
      r_block_start  <= 1'b0;
      r_frame_cnt    <= '0;
      r_overflow_cnt <= '0;
      r_idx          <= '0;
    end else begin
      r_cs_f        <= adc_cs;
      r_cs_ff       <= r_cs_f;
      r_wr_en       <= w_write;
      r_block_start <= w_first_word;
      if (w_strobe) begin
        r_smp_a <= adc_data_a;
        r_smp_b <= adc_data_b;
      end
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_ovf_inc && r_overflow_cnt != 8'hFF) r_overflow_cnt <= r_overflow_cnt + 8'd1;
      if (w_first_word) r_idx <= '0;
      else if (w_write) r_idx <= r_idx + 1'b1;
    end
  end

  assign fifo_din_a   = r_smp_a;
  assign fifo_din_b   = r_smp_b;
  assign fifo_wr_en   = r_wr_en;
  assign block_start  = r_block_start;
  assign frame_cnt    = r_frame_cnt;
  assign overflow_cnt = r_overflow_cnt;
  assign busy         = (r_state == S_CAPTURE);

endmodule

// File: tb/tb_adc_block_framer.sv
// Bench for adc_block_framer: scoreboard of expected FIFO words plus table-driven space checks.
module tb_adc_block_framer;
  localparam int BL = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        adc_cs;
  logic [15:0] adc_data_a;
  logic [15:0] adc_data_b;
  logic        start;
  logic [15:0] porog;
  logic        porog_valid;
  logic [8:0]  fifo_wr_count;
  logic [15:0] fifo_din_a;
  logic [15:0] fifo_din_b;
  logic        fifo_wr_en;
  logic        block_start;
  logic [15:0] frame_cnt;
  logic [7:0]  overflow_cnt;
  logic        busy;

  always #5 clk = ~clk;

  adc_block_framer #(.BLOCK_LEN(BL), .FIFO_DEPTH(512), .CNT_W(9)) dut (
    .clk(clk), .reset(reset), .adc_cs(adc_cs), .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
    .start(start), .porog(porog), .porog_valid(porog_valid), .fifo_wr_count(fifo_wr_count),
    .fifo_din_a(fifo_din_a), .fifo_din_b(fifo_din_b), .fifo_wr_en(fifo_wr_en),
    .block_start(block_start), .frame_cnt(frame_cnt), .overflow_cnt(overflow_cnt), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bs;
  } exp_t;

  typedef struct {
    logic [8:0] cnt;
    bit         starts;
  } vec_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_writes = 0;
  int   exp_writes = 0;
  int   exp_frame = 0;
  int   exp_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  exp_t m_e;
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      n_writes++;
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(fifo_din_a), 32'hFFFF_FFFF);
      end else begin
        m_e = q.pop_front();
        chk("din_a", 32'(fifo_din_a), 32'(m_e.a));
        chk("din_b", 32'(fifo_din_b), 32'(m_e.b));
        chk("block_start", 32'(block_start), 32'(m_e.bs));
      end
    end else if (block_start === 1'b1) begin
      chk("stray_block_start", 32'(block_start), 32'd0);
    end
  end

  task automatic push_exp(input logic [15:0] a, input bit bs);
    exp_t e;
    e.a = a;
    e.b = a ^ 16'hA5A5;
    e.bs = bs;
    q.push_back(e);
    exp_writes++;
  endtask

  // One CS conversion pulse: 3 cycles high, 3 low; data held from the rise until the next pulse.
  task automatic pulse(input logic [15:0] a, input bit expect_wr, input bit bs);
    @(posedge clk); #1;
    adc_data_a = a;
    adc_data_b = a ^ 16'hA5A5;
    adc_cs     = 1'b1;
    if (expect_wr) push_exp(a, bs);
    repeat (3) @(posedge clk);
    #1 adc_cs = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    chk({name, "_queue_empty"}, 32'(q.size()), 32'd0);
    chk({name, "_write_count"}, 32'(n_writes), 32'(exp_writes));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vecs[4];
  int   lat;
  bit   seen;

  initial begin
    vecs[0] = '{cnt: 9'd257, starts: 1'b0};
    vecs[1] = '{cnt: 9'd511, starts: 1'b0};
    vecs[2] = '{cnt: 9'd256, starts: 1'b1};
    vecs[3] = '{cnt: 9'd0,   starts: 1'b1};

    reset = 1'b1; adc_cs = 1'b0; start = 1'b0; porog = '0; porog_valid = 1'b0;
    adc_data_a = '0; adc_data_b = '0; fifo_wr_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_block_start", 32'(block_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", 32'({fifo_din_a, fifo_din_b}), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_overflow_cnt", 32'(overflow_cnt), 32'd0);
    reset = 1'b0;

`ifndef ADC_TRIGGER_EN
    // Continuous capture: two full blocks, then the FIFO reports no room.
    start = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 600; i++) begin
      if (i == 512) fifo_wr_count = 9'd300;
      pulse(16'(i), i < 512, (i % BL) == 0);
      if (i >= 512) exp_ovf++;
    end
    exp_frame = 2;
    drain("cont");
    chk("cont_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    chk("cont_overflow_cnt", 32'(overflow_cnt), 32'(exp_ovf));
    chk("cont_busy", 32'(busy), 32'd0);

    // Space-check boundary table; once started, the count is not re-checked inside the block.
    for (int v = 0; v < 4; v++) begin
      fifo_wr_count = vecs[v].cnt;
      pulse(16'h4000 + 16'(v * 16'h400), vecs[v].starts, 1'b1);
      if (!vecs[v].starts) exp_ovf++;
      chk($sformatf("space%0d_overflow_cnt", v), 32'(overflow_cnt), 32'(exp_ovf));
      chk($sformatf("space%0d_busy", v), 32'(busy), 32'(vecs[v].starts));
      if (vecs[v].starts) begin
        fifo_wr_count = 9'd511;
        for (int w = 1; w < BL; w++) pulse(16'h4000 + 16'(v * 16'h400) + 16'(w), 1'b1, 1'b0);
        exp_frame++;
        drain($sformatf("space%0d", v));
        chk($sformatf("space%0d_frame_cnt", v), 32'(frame_cnt), 32'(exp_frame));
      end
    end

    // Overflow counter saturates at 255.
    fifo_wr_count = 9'd300;
    while (exp_ovf < 255) begin
      pulse(16'h0BAD, 1'b0, 1'b0);
      exp_ovf++;
    end
    repeat (3) pulse(16'h0BAD, 1'b0, 1'b0);
    chk("ovf_saturate", 32'(overflow_cnt), 32'd255);

    // Stop mid-block: the block still completes, then nothing more is written.
    fifo_wr_count = 9'd0;
    for (int w = 0; w < BL; w++) begin
      pulse(16'h8000 + 16'(w), 1'b1, w == 0);
      if (w == 100) start = 1'b0;
    end
    exp_frame++;
    repeat (10) pulse(16'h0DEAD, 1'b0, 1'b0);
    drain("stop");
    chk("stop_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    chk("stop_busy", 32'(busy), 32'd0);

    // Reset during word 50 of a block.
    start = 1'b1;
    repeat (2) @(posedge clk);
    for (int w = 0; w < 50; w++) pulse(16'hC000 + 16'(w), 1'b1, w == 0);
    @(posedge clk); #1;
    adc_data_a = 16'hC032; adc_data_b = 16'hC032 ^ 16'hA5A5; adc_cs = 1'b1;
    push_exp(16'hC032, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (fifo_wr_en) seen = 1'b1;
    end
    chk("rst_mid_word50_seen", 32'(seen), 32'd1);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    adc_cs = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_frame = 0; exp_ovf = 0;
    chk("rst_mid_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    chk("rst_mid_overflow_cnt", 32'(overflow_cnt), 32'(exp_ovf));
    repeat (3) pulse(16'h0123, 1'b0, 1'b0);
    drain("rst_mid");

    // Latency: word written 2-3 clk edges after the CS rise is first sampled.
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    adc_data_a = 16'h1234; adc_data_b = 16'h1234 ^ 16'hA5A5; adc_cs = 1'b1;
    push_exp(16'h1234, 1'b1);
    lat = 0; seen = 1'b0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(posedge clk); #1;
      if (fifo_wr_en) begin seen = 1'b1; lat = c; end
    end
    chk("lat_in_window", 32'(seen && lat >= 2 && lat <= 3), 32'd1);
    chk("lat_din_a", 32'(fifo_din_a), 32'h1234);
    @(posedge clk); #1;
    chk("lat_one_cycle", 32'(fifo_wr_en), 32'd0);
    adc_cs = 1'b0;
    drain("lat");
    chk("lat_busy", 32'(busy), 32'd1);
`else
    // Trigger: threshold 100, step 110 starts a block; a step of exactly 100 does not.
    @(posedge clk); #1;
    porog = 16'd100; porog_valid = 1'b1;
    @(posedge clk); #1;
    porog_valid = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    pulse(16'd0, 1'b0, 1'b0);
    pulse(16'd50, 1'b0, 1'b0);
    chk("trig_no_start_50", 32'(busy), 32'd0);
    pulse(16'hFFC4, 1'b1, 1'b1);
    chk("trig_start_110", 32'(busy), 32'd1);
    for (int w = 1; w < BL; w++) pulse(16'hFFC4, 1'b1, 1'b0);
    exp_frame++;
    drain("trig_blk");
    chk("trig_frame_cnt", 32'(frame_cnt), 32'(exp_frame));
    pulse(16'h0028, 1'b0, 1'b0);
    chk("trig_step_100_no_start", 32'(busy), 32'd0);
    @(posedge clk); #1;
    porog = 16'hFFFE; porog_valid = 1'b1;
    @(posedge clk); #1;
    porog_valid = 1'b0;
    pulse(16'h7FFF, 1'b0, 1'b0);
    chk("trig_no_start_7fff", 32'(busy), 32'd0);
    pulse(16'h8000, 1'b1, 1'b1);
    chk("trig_start_65535", 32'(busy), 32'd1);
    drain("trig_max");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
